// File: rtl/wptr_full_ctrl_pkg.sv
// Shared async-FIFO definitions: default address width, depth and Gray-code helpers.
// Used by wptr_full_ctrl (optional almost-full flag enabled with WFULL_ALMOST_EN).
package wptr_full_ctrl_pkg;

  localparam int ADDRSIZE_DEF  = 4;
  localparam int AF_MARGIN_DEF = 2;

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs convert correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin_conv.sv
// Combinational Gray-to-binary converter, W bits wide.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/full controller of the dual-clock FIFO (binary + Gray pointers, count, overflow).
// Define WFULL_ALMOST_EN to add the registered walmost_full output.
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int ADDRSIZE  = ADDRSIZE_DEF,
  parameter int AF_MARGIN = AF_MARGIN_DEF
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                ovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wcount,
  output logic                wovf
`ifdef WFULL_ALMOST_EN
  ,
  output logic                walmost_full
`endif
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int DEPTH = fifo_depth(ADDRSIZE);

  if (ADDRSIZE < 2 || AF_MARGIN < 0 || AF_MARGIN > DEPTH) begin : g_bad_params
    $error("wptr_full_ctrl: ADDRSIZE must be >= 2 and AF_MARGIN within 0..depth");
  end

  // Handshake: a write is accepted on a wclk edge where winc=1 and wfull=0;
  // winc with wfull=1 is dropped and only raises wovf.
  logic          wacc;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wbnext;
  logic [PW-1:0] wgnext;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_ptr;
  logic [PW-1:0] wcount_next;

  gray2bin_conv #(.W(PW)) u_rptr_conv (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  assign wacc        = winc & ~wfull;
  assign wbnext      = wbin + PW'(wacc);
  assign wgnext      = PW'(bin2gray(32'(wbnext)));
  // Full when the write pointer has lapped the read pointer exactly once.
  assign full_ptr    = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  assign wcount_next = wbnext - rbin_s;
  assign waddr       = wbin[ADDRSIZE-1:0];

`ifdef WFULL_ALMOST_EN
  logic walmost_next;
  assign walmost_next = (wcount_next >= PW'(DEPTH - AF_MARGIN));
`endif

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wcount <= '0;
      wovf   <= 1'b0;
`ifdef WFULL_ALMOST_EN
      walmost_full <= 1'b0;
`endif
    end else begin
      wbin   <= wbnext;
      wptr   <= wgnext;
      wfull  <= (wgnext == full_ptr);
      wcount <= wcount_next;
      // Set has priority over clear so a drop is never lost.
      if (winc && wfull) begin
        wovf <= 1'b1;
      end else if (ovf_clr) begin
        wovf <= 1'b0;
      end
`ifdef WFULL_ALMOST_EN
      walmost_full <= walmost_next;
`endif
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: directed fill/overflow/drain/wrap cases plus random traffic
// checked against an occupancy model built from write and read totals.
module tb_wptr_full_ctrl;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          winc;
  logic [PW-1:0] wq2_rptr;
  logic          ovf_clr;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr;
  logic          wfull;
  logic [PW-1:0] wcount;
  logic          wovf;
`ifdef WFULL_ALMOST_EN
  logic          walmost_full;
`endif

  wptr_full_ctrl #(.ADDRSIZE(AW), .AF_MARGIN(AFM)) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .ovf_clr  (ovf_clr),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wcount   (wcount),
    .wovf     (wovf)
`ifdef WFULL_ALMOST_EN
    ,
    .walmost_full (walmost_full)
`endif
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: total accepted writes and total reads since reset.
  int   wr_tot;
  int   rd_tot;
  logic m_full;
  logic m_ovf;
  logic [16:0] exp_q[$];

  function automatic logic [PW-1:0] gray_of(input int n);
    int m;
    m = n % 32;
    return PW'(m ^ (m >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit inc, input bit clr);
    int occ;
    bit acc;
    acc = inc && !m_full;
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    if (acc) wr_tot++;
    occ    = wr_tot - rd_tot;
    m_full = (occ == DEPTH);
    exp_q.push_back({gray_of(wr_tot), 4'(wr_tot % DEPTH), m_full, 5'(occ), m_ovf,
                     1'(occ >= DEPTH - AFM)});
  endtask

  task automatic check_outputs();
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("wptr",   32'(wptr),   32'(e[16:12]));
    chk("waddr",  32'(waddr),  32'(e[11:8]));
    chk("wfull",  32'(wfull),  32'(e[7]));
    chk("wcount", 32'(wcount), 32'(e[6:2]));
    chk("wovf",   32'(wovf),   32'(e[1]));
`ifdef WFULL_ALMOST_EN
    chk("walmost_full", 32'(walmost_full), 32'(e[0]));
`endif
  endtask

  task automatic cycle(input bit inc, input int rd_adv, input bit clr);
    rd_tot  += rd_adv;
    winc     = inc;
    ovf_clr  = clr;
    wq2_rptr = gray_of(rd_tot);
    @(posedge wclk);
    model_edge(inc, clr);
    #1;
    check_outputs();
    winc    = 1'b0;
    ovf_clr = 1'b0;
  endtask

  // Asserts reset between edges and checks it takes effect before the next edge.
  task automatic do_reset();
    @(posedge wclk);
    #3;
    wrst = 1'b1;
    #1;
    chk("rst_wptr",   32'(wptr),   32'd0);
    chk("rst_waddr",  32'(waddr),  32'd0);
    chk("rst_wfull",  32'(wfull),  32'd0);
    chk("rst_wcount", 32'(wcount), 32'd0);
    chk("rst_wovf",   32'(wovf),   32'd0);
`ifdef WFULL_ALMOST_EN
    chk("rst_walmost_full", 32'(walmost_full), 32'd0);
`endif
    wr_tot   = 0;
    rd_tot   = 0;
    m_full   = 1'b0;
    m_ovf    = 1'b0;
    exp_q.delete();
    winc     = 1'b0;
    ovf_clr  = 1'b0;
    wq2_rptr = '0;
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  initial begin
    bit seen_top;
    bit seen_wrap;
    wrst     = 1'b1;
    winc     = 1'b0;
    ovf_clr  = 1'b0;
    wq2_rptr = '0;
    do_reset();

    // Fill 16 slots with the reader idle.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 0, 1'b0);
    chk("fill_wptr",   32'(wptr),   32'b11000);
    chk("fill_waddr",  32'(waddr),  32'd0);
    chk("fill_wcount", 32'(wcount), 32'd16);
    chk("fill_wfull",  32'(wfull),  32'd1);

    // Overflow, then set-vs-clear priority, then clear alone.
    cycle(1'b1, 0, 1'b0);
    chk("ovf_wptr_hold", 32'(wptr), 32'b11000);
    chk("ovf_set",       32'(wovf), 32'd1);
    cycle(1'b1, 0, 1'b1);
    chk("ovf_set_wins",  32'(wovf), 32'd1);
    cycle(1'b0, 0, 1'b1);
    chk("ovf_cleared",   32'(wovf), 32'd0);

    // One read while full.
    cycle(1'b0, 1, 1'b0);
    chk("drain_wfull",  32'(wfull),  32'd0);
    chk("drain_wcount", 32'(wcount), 32'd15);
`ifdef WFULL_ALMOST_EN
    chk("drain_almost", 32'(walmost_full), 32'd1);
`endif

    // Wrap: write then read, 40 times.
    do_reset();
    seen_top  = 1'b0;
    seen_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 0, 1'b0);
      if (wptr == 5'b10000) seen_top = 1'b1;
      if (seen_top && wptr == 5'b00000) seen_wrap = 1'b1;
      cycle(1'b0, 1, 1'b0);
    end
    chk("wrap_seen_top",  32'(seen_top),  32'd1);
    chk("wrap_seen_zero", 32'(seen_wrap), 32'd1);

    // Simultaneous write and read at count 15.
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1'b1, 0, 1'b0);
    cycle(1'b1, 1, 1'b0);
    chk("simul_wcount", 32'(wcount), 32'd15);
    chk("simul_wfull",  32'(wfull),  32'd0);
    chk("simul_waddr",  32'(waddr),  32'd0);

    // Random traffic with occasional mid-run resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit inc;
      bit clr;
      int adv;
      inc = ($urandom_range(0, 3) != 0);
      adv = (rd_tot < wr_tot && $urandom_range(0, 2) == 0) ? 1 : 0;
      clr = ($urandom_range(0, 15) == 0);
      cycle(inc, adv, clr);
      if (i % 200 == 199) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
